modbus_rtu_frame_rx: RTL

//  Consumes bytes from the UART byte receiver (rx_data/rx_done) and delimits Modbus RTU frames by line silence.
//  - Frame end: t3.5 of silence. Inter-character violation: gap > t1.5.
//  - Filters on slave address (own or broadcast 0x00), runs CRC-16/Modbus, streams accepted bytes downstream.
//  - Reports per-frame status to the request decoder.

---
 rtl/modbus_rtu_frame_rx_pkg.sv | 35 +++
 rtl/modbus_rtu_frame_rx_crc16.sv | 24 ++
 rtl/modbus_rtu_frame_rx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/modbus_rtu_frame_rx_pkg.sv
// Shared constants, state encoding and timing helpers for the Modbus RTU receive path.
package modbus_rtu_frame_rx_pkg;

    localparam logic [15:0] CRC_INIT       = 16'hFFFF;
    localparam logic [15:0] CRC_POLY       = 16'hA001;
    localparam logic [7:0]  BROADCAST_ADDR = 8'h00;
    localparam int unsigned MIN_FRAME_LEN  = 4;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_SKIP,
        ST_RECV,
        ST_DONE
    } rx_state_t;

    // Above 19200 baud the inter-character limit is fixed at 750 us.
    function automatic int unsigned calc_t15(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        if (baud_rate > 19200)
            return (clk_freq / 1000000) * 750;
        else
            return ((clk_freq / baud_rate) * 165) / 10;
    endfunction

    // Above 19200 baud the inter-frame limit is fixed at 1750 us.
    function automatic int unsigned calc_t35(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        if (baud_rate > 19200)
            return (clk_freq / 1000000) * 1750;
        else
            return ((clk_freq / baud_rate) * 385) / 10;
    endfunction

endpackage

// File: rtl/modbus_rtu_frame_rx_crc16.sv
// One-byte CRC-16/Modbus update, fully combinational (8 reflected bit-steps).
module modbus_crc16_byte
    import modbus_rtu_frame_rx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [15:0] crc_out
);

    logic [15:0] acc;

    // Shift the byte through the reflected polynomial LSB first.
    always_comb begin
        acc = crc_in ^ {8'h00, data_byte};
        for (int unsigned i = 0; i < 8; i++) begin
            if (acc[0])
                acc = (acc >> 1) ^ CRC_POLY;
            else
                acc = acc >> 1;
        end
        crc_out = acc;
    end

endmodule

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver: silence-delimited framing, address filter, CRC check, byte streaming.
module modbus_rtu_frame_rx
    import modbus_rtu_frame_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned MAX_LEN   = 256
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic [7:0] dev_addr,
    output logic       busy,
    output logic       frame_start,
    output logic [7:0] frame_byte,
    output logic       frame_byte_vld,
    output logic [7:0] frame_byte_idx,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [8:0] frame_len,
    output logic       err_crc,
    output logic       err_gap,
    output logic       err_ovf
);

    localparam int unsigned T15   = calc_t15(CLK_FREQ, BAUD_RATE);
    localparam int unsigned T35   = calc_t35(CLK_FREQ, BAUD_RATE);
    localparam int unsigned SIL_W = $clog2(T35 + 1);

    localparam logic [SIL_W-1:0] SIL_T15 = SIL_W'(T15);
    localparam logic [SIL_W-1:0] SIL_T35 = SIL_W'(T35);
    localparam logic [8:0]       LEN_MAX = 9'(MAX_LEN);
    localparam logic [8:0]       LEN_MIN = 9'(MIN_FRAME_LEN);

    rx_state_t        state;
    logic [SIL_W-1:0] silence;
    logic             silence_full;
    logic [15:0]      crc;
    logic [15:0]      crc_base;
    logic [15:0]      crc_next;
    logic [8:0]       len;
    logic             gap_seen;
    logic             ovf_seen;
    logic             addr_hit;
    logic             frame_long;

    assign silence_full = (silence == SIL_T35);
    assign addr_hit     = (rx_data == dev_addr) || (rx_data == BROADCAST_ADDR);
    assign frame_long   = (len >= LEN_MIN);
    // The address byte starts a fresh CRC; later bytes chain on the running value.
    assign crc_base     = (state == ST_RECV) ? crc : CRC_INIT;

    modbus_crc16_byte u_crc (
        .crc_in    (crc_base),
        .data_byte (rx_data),
        .crc_out   (crc_next)
    );

    // Line-silence timer: restarts on every byte, saturates at the frame-end limit.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            silence <= '0;
        else if (rx_done)
            silence <= '0;
        else if (!silence_full)
            silence <= silence + 1'b1;
    end

    // Frame FSM with registered strobes, byte stream and end-of-frame status.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= ST_WAIT_IDLE;
            busy           <= 1'b0;
            frame_start    <= 1'b0;
            frame_byte     <= '0;
            frame_byte_vld <= 1'b0;
            frame_byte_idx <= '0;
            frame_done     <= 1'b0;
            frame_ok       <= 1'b0;
            frame_len      <= '0;
            err_crc        <= 1'b0;
            err_gap        <= 1'b0;
            err_ovf        <= 1'b0;
            crc            <= CRC_INIT;
            len            <= '0;
            gap_seen       <= 1'b0;
            ovf_seen       <= 1'b0;
        end else begin
            frame_start    <= 1'b0;
            frame_byte_vld <= 1'b0;
            frame_done     <= 1'b0;
            unique case (state)
                ST_WAIT_IDLE: begin
                    if (!rx_done && silence_full)
                        state <= ST_IDLE;
                end
                ST_SKIP: begin
                    if (!rx_done && silence_full) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                // A byte arriving during the DONE cycle is treated as a new address byte.
                ST_IDLE, ST_DONE: begin
                    if (rx_done) begin
                        busy <= 1'b1;
                        if (addr_hit) begin
                            state          <= ST_RECV;
                            frame_start    <= 1'b1;
                            frame_byte     <= rx_data;
                            frame_byte_vld <= 1'b1;
                            frame_byte_idx <= '0;
                            len            <= 9'd1;
                            crc            <= crc_next;
                            gap_seen       <= 1'b0;
                            ovf_seen       <= 1'b0;
                        end else begin
                            state <= ST_SKIP;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (rx_done) begin
                        if (silence > SIL_T15)
                            gap_seen <= 1'b1;
                        if (len < LEN_MAX) begin
                            frame_byte     <= rx_data;
                            frame_byte_vld <= 1'b1;
                            frame_byte_idx <= len[7:0];
                            len            <= len + 9'd1;
                            crc            <= crc_next;
                        end else begin
                            ovf_seen <= 1'b1;
                        end
                    end else if (silence_full) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                        frame_len  <= len;
                        frame_ok   <= (crc == '0) && frame_long && !gap_seen && !ovf_seen;
                        err_crc    <= frame_long && (crc != '0);
                        err_gap    <= frame_long && gap_seen;
                        err_ovf    <= ovf_seen;
                    end
                end
                default: state <= ST_WAIT_IDLE;
            endcase
        end
    end

endmodule
